// File: rtl/or_quad_bist_seq.sv
// Self-test sequencer for a quad 2-input OR package: sweeps the truth table and flags failing lanes.
// Optional macro OR_BIST_ERRCNT_EN adds the ERR_COUNT output (saturating count of mismatching lane-checks).
module or_quad_bist_seq #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ROUNDS        = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [3:0] Y,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_MASK,
  output logic       FIRST_FAIL_VALID,
  output logic [1:0] FIRST_FAIL_VEC
`ifdef OR_BIST_ERRCNT_EN
  ,
  output logic [7:0] ERR_COUNT
`endif
);

  localparam int SETTLE_N = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int ROUNDS_N = (ROUNDS < 1) ? 1 : ROUNDS;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_N - 1);
  localparam logic [15:0] ROUNDS_LAST = 16'(ROUNDS_N - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FIN} state_t;

  state_t      state, state_nx;
  logic [1:0]  vec, vec_nx;
  logic [15:0] round_cnt, round_nx;
  logic [15:0] settle_cnt, settle_nx;
  logic [3:0]  a_nx, b_nx, mask_nx, mismatch;
  logic        busy_nx, done_nx, pass_nx, ffv_nx;
  logic [1:0]  ffvec_nx;
  logic [7:0]  err_q, err_nx;
  logic [8:0]  err_sum;

  // Lane i gets pattern (v+i) mod 4; pattern k drives A=~k[0], B=~k[1].
  function automatic logic [7:0] vec_ab(input logic [1:0] v);
    logic [3:0] a, b;
    logic [1:0] k;
    for (int i = 0; i < 4; i++) begin
      k    = v + 2'(i);
      a[i] = ~k[0];
      b[i] = ~k[1];
    end
    return {a, b};
  endfunction

  function automatic logic [8:0] popcount4(input logic [3:0] m);
    logic [8:0] c;
    c = 9'd0;
    for (int i = 0; i < 4; i++) c = c + {8'd0, m[i]};
    return c;
  endfunction

  // Case inequality so an X or Z on Y counts as a failed lane.
  always_comb begin
    mismatch = 4'b0000;
    for (int i = 0; i < 4; i++) mismatch[i] = (Y[i] !== (A[i] | B[i]));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      vec              <= 2'd0;
      round_cnt        <= 16'd0;
      settle_cnt       <= 16'd0;
      A                <= 4'b0000;
      B                <= 4'b0000;
      BUSY             <= 1'b0;
      DONE             <= 1'b0;
      PASS             <= 1'b0;
      FAIL_MASK        <= 4'b0000;
      FIRST_FAIL_VALID <= 1'b0;
      FIRST_FAIL_VEC   <= 2'd0;
      err_q            <= 8'd0;
    end else begin
      state            <= state_nx;
      vec              <= vec_nx;
      round_cnt        <= round_nx;
      settle_cnt       <= settle_nx;
      A                <= a_nx;
      B                <= b_nx;
      BUSY             <= busy_nx;
      DONE             <= done_nx;
      PASS             <= pass_nx;
      FAIL_MASK        <= mask_nx;
      FIRST_FAIL_VALID <= ffv_nx;
      FIRST_FAIL_VEC   <= ffvec_nx;
      err_q            <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    vec_nx    = vec;
    round_nx  = round_cnt;
    settle_nx = settle_cnt;
    a_nx      = A;
    b_nx      = B;
    busy_nx   = BUSY;
    done_nx   = DONE;
    pass_nx   = PASS;
    mask_nx   = FAIL_MASK;
    ffv_nx    = FIRST_FAIL_VALID;
    ffvec_nx  = FIRST_FAIL_VEC;
    err_nx    = err_q;
    err_sum   = {1'b0, err_q} + popcount4(mismatch);
    case (state)
      IDLE, FIN: begin
        if (START) begin
          state_nx     = SETTLE;
          vec_nx       = 2'd0;
          round_nx     = 16'd0;
          settle_nx    = 16'd0;
          {a_nx, b_nx} = vec_ab(2'd0);
          busy_nx      = 1'b1;
          done_nx      = 1'b0;
          pass_nx      = 1'b0;
          mask_nx      = 4'b0000;
          ffv_nx       = 1'b0;
          ffvec_nx     = 2'd0;
          err_nx       = 8'd0;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nx  = CHECK;
          settle_nx = 16'd0;
        end else begin
          settle_nx = settle_cnt + 16'd1;
        end
      end
      CHECK: begin
        mask_nx = FAIL_MASK | mismatch;
        err_nx  = err_sum[8] ? 8'hFF : err_sum[7:0];
        if ((mismatch != 4'b0000) && !FIRST_FAIL_VALID) begin
          ffv_nx   = 1'b1;
          ffvec_nx = vec;
        end
        if (vec != 2'd3) begin
          vec_nx       = vec + 2'd1;
          {a_nx, b_nx} = vec_ab(vec + 2'd1);
          state_nx     = SETTLE;
        end else if (round_cnt != ROUNDS_LAST) begin
          round_nx     = round_cnt + 16'd1;
          vec_nx       = 2'd0;
          {a_nx, b_nx} = vec_ab(2'd0);
          state_nx     = SETTLE;
        end else begin
          state_nx = FIN;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          pass_nx  = (mask_nx == 4'b0000);
          a_nx     = 4'b0000;
          b_nx     = 4'b0000;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef OR_BIST_ERRCNT_EN
  assign ERR_COUNT = err_q;
`endif

endmodule
